// File: rtl/exe_mem_pkg.sv
// Shared definitions for the EXE->MEM pipeline register: memop encodings,
// default widths, the reference payload layout and a payload-width helper.
`timescale 1ns/1ps
package exe_mem_pkg;

    localparam logic [1:0] MEMOP_NONE  = 2'b00;
    localparam logic [1:0] MEMOP_READ  = 2'b01;
    localparam logic [1:0] MEMOP_WRITE = 2'b10;
    localparam logic [1:0] MEMOP_RSVD  = 2'b11;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_W  = 4;

    // Payload field order at the default widths; the top mirrors this order
    // with its own parameterised widths.
    typedef struct packed {
        logic [1:0]            ctl;
        logic                  wb;
        logic [DEF_DATA_W-1:0] alu;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_REG_W-1:0]  wreg;
    } exe_mem_payload_t;

    function automatic int payload_width(input int data_w, input int reg_w);
        return 3 + 2 * data_w + reg_w;
    endfunction

endpackage

// File: rtl/exe_mem_skid.sv
// One-entry skid buffer, payload-width generic. Captures an instruction
// accepted while the downstream output register is held, and releases it
// when the output register is free again or the stage is flushed.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_EMPTY | no parked entry; upstream may present a new instruction
// ST_FULL  | one entry parked, waiting for the output register to free
`timescale 1ns/1ps
module exe_mem_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_next;
    end

    // Next-state: fill on push while empty; drain on pop or flush.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_EMPTY: if (push && !flush) w_next = ST_FULL;
            ST_FULL:  if (pop || flush)   w_next = ST_EMPTY;
            default:  w_next = ST_EMPTY;
        endcase
    end

    // Capture the parked payload only when the slot is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_data <= '0;
        else if (push && (r_state == ST_EMPTY))   r_data <= din;
    end

    assign dout = r_data;
    assign full = (r_state == ST_FULL);

endmodule

// File: rtl/exe_mem_pipe.sv
// EXE->MEM pipeline register with valid/ready handshake, flush, memop decode,
// forwarding qualifier, illegal-memop pulse and saturating stall counter.
// Optional feature macro: EXE_MEM_SKID_EN adds a one-entry skid buffer and
// makes in_ready a registered signal; without it in_ready is combinational.
`timescale 1ns/1ps
module exe_mem_pipe
    import exe_mem_pkg::*;
#(
    parameter int               DATA_W      = DEF_DATA_W,
    parameter int               REG_W       = DEF_REG_W,
    parameter logic [REG_W-1:0] NOP_REG     = {REG_W{1'b1}},
    parameter int               STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             controlmem_in,
    input  logic                   controlwb_in,
    input  logic [DATA_W-1:0]      alu_in,
    input  logic [DATA_W-1:0]      wdata_in,
    input  logic [REG_W-1:0]       wreg_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   memread_out,
    output logic                   memwrite_out,
    output logic                   controlwb_out,
    output logic [DATA_W-1:0]      alu_out,
    output logic [DATA_W-1:0]      wdata_out,
    output logic [REG_W-1:0]       wreg_out,
    output logic                   fwd_valid,
    output logic                   illegal_op,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [1:0]        ctl;
        logic              wb;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  wreg;
    } pl_t;

    logic                   r_valid;
    logic                   r_memread;
    logic                   r_memwrite;
    logic                   r_wb;
    logic [DATA_W-1:0]      r_alu;
    logic [DATA_W-1:0]      r_wdata;
    logic [REG_W-1:0]       r_wreg;
    logic                   r_illegal;
    logic [STALL_CNT_W-1:0] r_stall;

    logic                   w_load;
    logic                   w_accept;
    logic                   w_src_valid;
    pl_t                    w_in_pl;
    pl_t                    w_src_pl;

    // The output register may take new contents when empty or being consumed.
    assign w_load  = ~r_valid | out_ready;
    assign w_in_pl = '{ctl: controlmem_in, wb: controlwb_in, alu: alu_in,
                       wdata: wdata_in, wreg: wreg_in};

`ifdef EXE_MEM_SKID_EN
    localparam int PL_W = payload_width(DATA_W, REG_W);

    logic              w_skid_full;
    logic              w_push;
    logic              w_pop;
    logic [PL_W-1:0]   w_skid_dout;

    // A parked entry always has priority over the input; while parked,
    // in_ready is low so the two never compete.
    assign in_ready    = ~w_skid_full;
    assign w_accept    = in_valid & in_ready;
    assign w_push      = w_accept & ~w_load & ~flush;
    assign w_pop       = w_skid_full & w_load;
    assign w_src_pl    = w_skid_full ? pl_t'(w_skid_dout) : w_in_pl;
    assign w_src_valid = w_skid_full | w_accept;

    exe_mem_skid #(.W(PL_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_in_pl),
        .dout  (w_skid_dout),
        .full  (w_skid_full)
    );
`else
    assign in_ready    = w_load;
    assign w_accept    = in_valid & in_ready;
    assign w_src_pl    = w_in_pl;
    assign w_src_valid = w_accept;
`endif

    // Output register: flush and bubbles clear controls, data fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_wb       <= 1'b0;
            r_alu      <= '0;
            r_wdata    <= '0;
            r_wreg     <= NOP_REG;
            r_illegal  <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            if (flush || (w_load && !w_src_valid)) begin
                r_valid    <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_wb       <= 1'b0;
                r_wreg     <= NOP_REG;
            end else if (w_load) begin
                r_valid    <= 1'b1;
                r_memread  <= (w_src_pl.ctl == MEMOP_READ);
                r_memwrite <= (w_src_pl.ctl == MEMOP_WRITE);
                r_wb       <= w_src_pl.wb;
                r_alu      <= w_src_pl.alu;
                r_wdata    <= w_src_pl.wdata;
                r_wreg     <= w_src_pl.wreg;
                r_illegal  <= (w_src_pl.ctl == MEMOP_RSVD);
            end
        end
    end

    // Count cycles where MEM holds a live instruction it cannot consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall <= '0;
        else if (r_valid && !out_ready && !(&r_stall))
            r_stall <= r_stall + STALL_CNT_W'(1);
    end

    assign out_valid     = r_valid;
    assign memread_out   = r_memread;
    assign memwrite_out  = r_memwrite;
    assign controlwb_out = r_wb;
    assign alu_out       = r_alu;
    assign wdata_out     = r_wdata;
    assign wreg_out      = r_wreg;
    assign fwd_valid     = r_valid & r_wb & (r_wreg != NOP_REG);
    assign illegal_op    = r_illegal;
    assign stall_cnt     = r_stall;

endmodule

// File: tb/tb_exe_mem_pipe.sv
// Self-checking bench for exe_mem_pipe: directed scenarios followed by random
// traffic, compared against a queue-based model of the stage occupancy.
`timescale 1ns/1ps
module tb_exe_mem_pipe;
    import exe_mem_pkg::*;

    localparam int         DW  = 16;
    localparam int         RW  = 4;
    localparam int         SW  = 8;
    localparam logic [3:0] NOP = 4'hF;
`ifdef EXE_MEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk, rst, flush, in_valid, in_ready;
    logic [1:0]    controlmem_in;
    logic          controlwb_in;
    logic [DW-1:0] alu_in, wdata_in;
    logic [RW-1:0] wreg_in;
    logic          out_valid, out_ready;
    logic          memread_out, memwrite_out, controlwb_out;
    logic [DW-1:0] alu_out, wdata_out;
    logic [RW-1:0] wreg_out;
    logic          fwd_valid, illegal_op;
    logic [SW-1:0] stall_cnt;

    exe_mem_pipe #(.DATA_W(DW), .REG_W(RW), .NOP_REG(NOP), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .controlmem_in(controlmem_in), .controlwb_in(controlwb_in),
        .alu_in(alu_in), .wdata_in(wdata_in), .wreg_in(wreg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .memread_out(memread_out), .memwrite_out(memwrite_out),
        .controlwb_out(controlwb_out),
        .alu_out(alu_out), .wdata_out(wdata_out), .wreg_out(wreg_out),
        .fwd_valid(fwd_valid), .illegal_op(illegal_op), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of in-flight instructions whose head is what
    // MEM sees; capacity 1 without skid, 2 with skid.
    typedef struct {
        logic [1:0]    mem;
        logic          wb;
        logic [DW-1:0] alu;
        logic [DW-1:0] wd;
        logic [RW-1:0] wr;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] m_alu, m_wd;
    logic          m_ill;
    int            m_cnt;

    task automatic model_reset();
        q.delete();
        m_alu = '0;
        m_wd  = '0;
        m_ill = 1'b0;
        m_cnt = 0;
    endtask

    task automatic check_outputs();
        bit   v;
        ent_t h;
        v = (q.size() > 0);
        h = '{mem: 2'b00, wb: 1'b0, alu: '0, wd: '0, wr: NOP};
        if (v) h = q[0];
        check_val("out_valid", out_valid, v);
        check_val("memread", memread_out, v && (h.mem == MEMOP_READ));
        check_val("memwrite", memwrite_out, v && (h.mem == MEMOP_WRITE));
        check_val("controlwb", controlwb_out, v && h.wb);
        check_val("wreg_out", wreg_out, v ? h.wr : NOP);
        check_val("alu_out", alu_out, m_alu);
        check_val("wdata_out", wdata_out, m_wd);
        check_val("fwd_valid", fwd_valid, v && h.wb && (h.wr != NOP));
        check_val("illegal_op", illegal_op, m_ill);
        check_val("stall_cnt", stall_cnt, m_cnt);
    endtask

    // One clock: drive at the falling edge, check in_ready, advance the model,
    // then check all outputs at the next falling edge.
    task automatic step(input logic fl, input logic iv, input logic [1:0] mem, input logic wb,
                        input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                        input logic [RW-1:0] wr, input logic ordy);
        bit   exp_rdy, acc, had_head, popped;
        ent_t e;
        flush = fl; in_valid = iv; controlmem_in = mem; controlwb_in = wb;
        alu_in = alu; wdata_in = wd; wreg_in = wr; out_ready = ordy;
        #1;
        exp_rdy = SKID ? (q.size() < 2) : ((q.size() == 0) || ordy);
        check_val("in_ready", in_ready, exp_rdy);
        acc = iv && exp_rdy;
        if ((q.size() > 0) && !ordy && (m_cnt < 255)) m_cnt++;
        m_ill    = 1'b0;
        had_head = (q.size() > 0);
        popped   = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if ((q.size() > 0) && ordy) begin
                void'(q.pop_front());
                popped = 1'b1;
            end
            if (acc) begin
                e = '{mem: mem, wb: wb, alu: alu, wd: wd, wr: wr};
                q.push_back(e);
            end
            if ((popped || !had_head) && (q.size() > 0)) begin
                m_alu = q[0].alu;
                m_wd  = q[0].wd;
                m_ill = (q[0].mem == MEMOP_RSVD);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, ordy);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; controlmem_in = 2'b00;
        controlwb_in = 1'b0; alu_in = '0; wdata_in = '0; wreg_in = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        check_val("reset_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // 1: single read passes with one cycle latency
        step(1'b0, 1'b1, MEMOP_READ, 1'b1, 16'h1234, 16'h0000, 4'd3, 1'b1);
        check_val("t1_memread", memread_out, 1'b1);
        check_val("t1_alu", alu_out, 16'h1234);
        check_val("t1_fwd", fwd_valid, 1'b1);

        // 2: five cycles of backpressure with more input waiting
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, MEMOP_WRITE, 1'b0, 16'h5555 + 16'(i), 16'h0BAD, 4'd6, 1'b0);
        check_val("t2_stall", stall_cnt, 8'd5);
        check_val("t2_frozen", alu_out, 16'h1234);
        idle(3, 1'b1);

        // 3: flush beats a simultaneous accept
        step(1'b0, 1'b1, MEMOP_READ, 1'b1, 16'h0100, 16'h0200, 4'd1, 1'b0);
        step(1'b1, 1'b1, MEMOP_WRITE, 1'b1, 16'hAAAA, 16'hBBBB, 4'd5, 1'b1);
        check_val("t3_valid", out_valid, 1'b0);
        check_val("t3_wreg", wreg_out, 4'hF);
        idle(1, 1'b1);
        check_val("t3_dropped", out_valid, 1'b0);

        // 4: reserved memop
        step(1'b0, 1'b1, MEMOP_RSVD, 1'b1, 16'h0077, 16'h0088, 4'd2, 1'b1);
        check_val("t4_ill", illegal_op, 1'b1);
        check_val("t4_rd", memread_out, 1'b0);
        idle(1, 1'b1);
        check_val("t4_pulse", illegal_op, 1'b0);

        // 5: long hold saturates the stall counter
        step(1'b0, 1'b1, MEMOP_READ, 1'b1, 16'h0F0F, 16'h0E0E, 4'd7, 1'b1);
        idle(300, 1'b0);
        check_val("t5_sat", stall_cnt, 8'hFF);
        idle(3, 1'b1);

        // 6: asynchronous reset with the stage fully occupied
        step(1'b0, 1'b1, MEMOP_READ, 1'b1, 16'h1111, 16'h2222, 4'd4, 1'b0);
        step(1'b0, 1'b1, MEMOP_WRITE, 1'b1, 16'h3333, 16'h4444, 4'd8, 1'b0);
        step(1'b0, 1'b1, MEMOP_WRITE, 1'b1, 16'h5555, 16'h6666, 4'd9, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_val("t6_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
